// File: rtl/sobel3x3_line_buffer.sv
// 3x3 Sobel window front end: two cascaded line RAMs turn a raster pixel stream
// into one vertical 3-pixel column per input beat, with 1-clk latency sideband.
module sobel3x3_line_buffer #(
  parameter int DATA_WIDTH = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] matrix0_tdata,
  output logic [DATA_WIDTH-1:0] matrix1_tdata,
  output logic [DATA_WIDTH-1:0] matrix2_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int               COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  if (IMG_WIDTH < 2 || IMG_HEIGHT < 1) begin : g_bad_params
    $error("sobel3x3_line_buffer: IMG_WIDTH must be >= 2 and IMG_HEIGHT >= 1");
  end

  logic [DATA_WIDTH-1:0] ram_a [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] ram_b [IMG_WIDTH];

  logic [COL_W-1:0]      col_p0;
  logic [1:0]            line_idx_p0;
  logic [COL_W-1:0]      c_p0;
  logic [1:0]            li_p0;
  logic [DATA_WIDTH-1:0] rd_a_p0;
  logic [DATA_WIDTH-1:0] rd_b_p0;
  logic                  eol_p0;

  logic [DATA_WIDTH-1:0] m0_p1, m1_p1, m2_p1;
  logic                  vld_p1, last_p1, user_p1;

  // Stage p0: SOF forces column 0 / line 0; RAMs read before this beat overwrites them
  always_comb begin
    c_p0    = s_axis_tuser ? '0 : col_p0;
    li_p0   = s_axis_tuser ? 2'd0 : line_idx_p0;
    rd_a_p0 = ram_a[c_p0];
    rd_b_p0 = ram_b[c_p0];
    eol_p0  = s_axis_tlast || (c_p0 == LAST_COL);
  end

  always_ff @(posedge pixel_clk) begin
    if (s_axis_tvalid) begin
      ram_a[c_p0] <= s_axis_tdata;
      ram_b[c_p0] <= rd_a_p0;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0      <= '0;
      line_idx_p0 <= 2'd0;
    end else if (s_axis_tvalid) begin
      if (eol_p0) begin
        col_p0      <= '0;
        line_idx_p0 <= (li_p0 == 2'd2) ? 2'd2 : li_p0 + 2'd1;
      end else begin
        col_p0      <= c_p0 + 1'b1;
        line_idx_p0 <= li_p0;
      end
    end
  end

  // Stage p1: registered column; rows not yet filled in this frame read as 0
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_p1   <= '0;
      m1_p1   <= '0;
      m2_p1   <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      user_p1 <= 1'b0;
    end else begin
      vld_p1  <= s_axis_tvalid;
      last_p1 <= s_axis_tvalid & s_axis_tlast;
      user_p1 <= s_axis_tvalid & s_axis_tuser;
      if (s_axis_tvalid) begin
        m2_p1 <= s_axis_tdata;
        m1_p1 <= (li_p0 >= 2'd1) ? rd_a_p0 : '0;
        m0_p1 <= (li_p0 >= 2'd2) ? rd_b_p0 : '0;
      end
    end
  end

  assign matrix0_tdata = m0_p1;
  assign matrix1_tdata = m1_p1;
  assign matrix2_tdata = m2_p1;
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tuser  = user_p1;

endmodule

// File: tb/tb_sobel3x3_line_buffer.sv
// Bench for sobel3x3_line_buffer: per-column pixel history model checked every
// cycle, plus literal expectations for the directed frame scenarios.
module tb_sobel3x3_line_buffer;

  localparam int DW = 10;
  localparam int W  = 4;

  logic          pixel_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [DW-1:0] matrix0_tdata, matrix1_tdata, matrix2_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;

  sobel3x3_line_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(3)) dut (
    .pixel_clk     (pixel_clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .matrix0_tdata (matrix0_tdata),
    .matrix1_tdata (matrix1_tdata),
    .matrix2_tdata (matrix2_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position in the frame (x, y) and, per column, the last two pixels
  // ever stored at that column (the line above and the one above that).
  int x = 0, y = 0;
  int hist0 [W];
  int hist1 [W];
  int hist_n [W];
  int e0, e1, e2, ev, el, eu;
  bit k0, k1;

  initial begin
    for (int i = 0; i < W; i++) begin
      hist0[i] = 0; hist1[i] = 0; hist_n[i] = 0;
    end
    e0 = 0; e1 = 0; e2 = 0; ev = 0; el = 0; eu = 0; k0 = 1; k1 = 1;
  end

  always @(posedge pixel_clk) begin
    int c, li, p;
    if (!rst_n) begin
      x = 0; y = 0;
      e0 = 0; e1 = 0; e2 = 0; ev = 0; el = 0; eu = 0; k0 = 1; k1 = 1;
      if (s_axis_tvalid)
        for (int i = 0; i < W; i++) hist_n[i] = 0;
    end else begin
      ev = s_axis_tvalid;
      el = s_axis_tvalid & s_axis_tlast;
      eu = s_axis_tvalid & s_axis_tuser;
      if (s_axis_tvalid) begin
        p  = int'(s_axis_tdata);
        c  = s_axis_tuser ? 0 : x;
        li = s_axis_tuser ? 0 : y;
        e2 = p;
        if (li >= 1) begin k1 = (hist_n[c] >= 1); e1 = hist0[c]; end
        else begin k1 = 1; e1 = 0; end
        if (li >= 2) begin k0 = (hist_n[c] >= 2); e0 = hist1[c]; end
        else begin k0 = 1; e0 = 0; end
        hist1[c] = hist0[c];
        hist0[c] = p;
        if (hist_n[c] < 2) hist_n[c]++;
        if (s_axis_tlast || c == W - 1) begin
          x = 0; y = (li + 1 > 2) ? 2 : li + 1;
        end else begin
          x = c + 1; y = li;
        end
      end
    end
    #1;
    chk("m_axis_tvalid", int'(m_axis_tvalid), ev);
    chk("m_axis_tlast",  int'(m_axis_tlast),  el);
    chk("m_axis_tuser",  int'(m_axis_tuser),  eu);
    chk("matrix2", int'(matrix2_tdata), e2);
    if (k1) chk("matrix1", int'(matrix1_tdata), e1);
    if (k0) chk("matrix0", int'(matrix0_tdata), e0);
  end

  task automatic send(input int p, input bit l, input bit u);
    s_axis_tdata  = DW'(p);
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    @(negedge pixel_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = DW'($urandom);
      s_axis_tlast  = 1'($urandom);
      s_axis_tuser  = 1'($urandom);
      @(negedge pixel_clk);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_m0"}, int'(matrix0_tdata), 0);
    chk({nm, "_m1"}, int'(matrix1_tdata), 0);
    chk({nm, "_m2"}, int'(matrix2_tdata), 0);
    chk({nm, "_vld"}, int'(m_axis_tvalid), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge pixel_clk);
    // reset held while beats arrive
    send(5, 1'b0, 1'b1);
    send(6, 1'b1, 1'b0);
    chk_zero("rst_hold");
    idle(1);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_idle_vld", int'(m_axis_tvalid), 0);
    send(7, 1'b0, 1'b1);
    chk("first_beat_m2", int'(matrix2_tdata), 7);
    chk("first_beat_vld", int'(m_axis_tvalid), 1);
    chk("first_beat_user", int'(m_axis_tuser), 1);
    idle(2);

    // three full lines, pixel = 16*line + col
    for (int ln = 0; ln < 3; ln++)
      for (int cl = 0; cl < W; cl++) begin
        send(16 * ln + cl, cl == W - 1, ln == 0 && cl == 0);
        if (ln == 0 && cl == 0) begin
          chk("l0_m1", int'(matrix1_tdata), 0);
          chk("l0_m0", int'(matrix0_tdata), 0);
        end
        if (ln == 2 && cl == 1) begin
          chk("l2c1_m2", int'(matrix2_tdata), 33);
          chk("l2c1_m1", int'(matrix1_tdata), 17);
          chk("l2c1_m0", int'(matrix0_tdata), 1);
        end
        if (ln == 0 && cl == W - 1) chk("l0_last", int'(m_axis_tlast), 1);
      end
    idle(1);

    // same frame with one valid beat every third clock
    for (int ln = 0; ln < 3; ln++)
      for (int cl = 0; cl < W; cl++) begin
        send(16 * ln + cl, cl == W - 1, ln == 0 && cl == 0);
        if (ln == 2 && cl == 1) begin
          chk("gap_m1", int'(matrix1_tdata), 17);
          chk("gap_m0", int'(matrix0_tdata), 1);
        end
        idle(2);
        if (ln == 2 && cl == 1) begin
          chk("gap_hold_m2", int'(matrix2_tdata), 33);
          chk("gap_hold_vld", int'(m_axis_tvalid), 0);
        end
      end

    // no tlast: the column counter wraps on its own
    for (int i = 0; i < 8; i++) begin
      send(100 + i, 1'b0, i == 0);
      if (i == 4) begin
        chk("wrap_m1", int'(matrix1_tdata), 100);
        chk("wrap_m0", int'(matrix0_tdata), 0);
      end
    end
    idle(1);

    // second SOF in the middle of line 1
    for (int cl = 0; cl < W; cl++) send(150 + cl, cl == W - 1, cl == 0);
    send(160, 1'b0, 1'b0);
    send(161, 1'b0, 1'b0);
    send(200, 1'b0, 1'b1);
    chk("sof_mid_m2", int'(matrix2_tdata), 200);
    chk("sof_mid_m1", int'(matrix1_tdata), 0);
    chk("sof_mid_m0", int'(matrix0_tdata), 0);
    chk("sof_mid_user", int'(m_axis_tuser), 1);
    send(201, 1'b1, 1'b0);
    idle(1);

    // one-clock reset in the middle of line 2
    for (int ln = 0; ln < 3; ln++)
      for (int cl = 0; cl < W; cl++) begin
        if (ln == 2 && cl == 2) break;
        send(16 * ln + cl + 500, cl == W - 1, ln == 0 && cl == 0);
      end
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    @(negedge pixel_clk);
    rst_n = 1'b1;
    for (int cl = 0; cl < W; cl++) begin
      send(300 + cl, cl == W - 1, 1'b0);
      if (cl == 0) begin
        chk("rst_l0_m1", int'(matrix1_tdata), 0);
        chk("rst_l0_m0", int'(matrix0_tdata), 0);
      end
    end
    send(310, 1'b0, 1'b0);
    chk("rst_l1_m1", int'(matrix1_tdata), 300);
    chk("rst_l1_m0", int'(matrix0_tdata), 0);
    idle(1);

    // random traffic: gaps, short lines, missing tlast, stray SOF
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 7)
        send(int'($urandom_range(0, 1023)), $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
      else
        idle(1);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
